// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: classifies each retired instruction and queues it in a FIFO.
// Define RETIRE_TRACE_CLASS_COUNTERS_EN to add per-class retirement counters.
module retire_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_en,
    input  logic [5:0]                 class_mask,
    input  logic                       clr,
    input  logic                       ret_valid,
    input  logic [XLEN-1:0]            ret_pc,
    input  logic [31:0]                ret_instr,
    input  logic                       ret_rd_we,
    input  logic [XLEN-1:0]            ret_wb_data,
    input  logic                       ret_br_taken,
    input  logic [XLEN-1:0]            ret_mem_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_class,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
    ,
    output logic [6*CNT_W-1:0]         class_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_IALU   = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_OTHER  = 3'd5;

    logic [2:0]      cls;
    logic [XLEN-1:0] payload;
    logic            instr_nz;
    logic            capture;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [2:0]      mem_cls_q   [DEPTH];
    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic [XLEN-1:0] mem_data_q  [DEPTH];

    always_comb begin
        cls = CLS_OTHER;
        unique case (ret_instr[6:0])
            7'b0110011: cls = CLS_R;
            7'b0010011: cls = CLS_IALU;
            7'b0000011: cls = CLS_LOAD;
            7'b0100011: cls = CLS_STORE;
            7'b1100011: cls = CLS_BRANCH;
            default:    cls = CLS_OTHER;
        endcase
    end

    // Register writes win; otherwise pick the class-specific side information.
    always_comb begin
        payload = '0;
        if (ret_rd_we) begin
            payload = ret_wb_data;
        end else if (cls == CLS_STORE) begin
            payload = ret_mem_addr;
        end else if (cls == CLS_BRANCH) begin
            payload = {{(XLEN-1){1'b0}}, ret_br_taken};
        end
    end

    always_comb begin
        instr_nz = |ret_instr;
        capture  = ret_valid & trace_en & class_mask[cls] & instr_nz;
        full     = (level_q == LW'(DEPTH));
        pop      = out_valid & out_ready;
        push     = capture & (~full | pop);
        drop     = capture & full & ~pop;
    end

    always_comb begin
        level_d  = level_q + LW'(push) - LW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // A clear in the same cycle as a drop still leaves the flag and count at zero.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (~&drop_cnt_q) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_cls_q[wr_ptr_q]   <= cls;
            mem_pc_q[wr_ptr_q]    <= ret_pc;
            mem_instr_q[wr_ptr_q] <= ret_instr;
            mem_data_q[wr_ptr_q]  <= payload;
        end
    end

    always_comb begin
        out_valid  = (level_q != '0);
        out_class  = mem_cls_q[rd_ptr_q];
        out_pc     = mem_pc_q[rd_ptr_q];
        out_instr  = mem_instr_q[rd_ptr_q];
        out_data   = mem_data_q[rd_ptr_q];
        level      = level_q;
        overflow   = overflow_q;
        drop_count = drop_cnt_q;
    end

`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
    logic [CNT_W-1:0] cls_cnt_q [6];
    logic [CNT_W-1:0] cls_cnt_d [6];

    // Counts every real retirement, regardless of filtering or FIFO state.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            cls_cnt_d[k] = cls_cnt_q[k];
            if (clr) begin
                cls_cnt_d[k] = '0;
            end else if (ret_valid && instr_nz && cls == 3'(k)) begin
                if (~&cls_cnt_q[k]) begin
                    cls_cnt_d[k] = cls_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 6; k++) begin
                cls_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 6; k++) begin
                cls_cnt_q[k] <= cls_cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            class_count[k*CNT_W +: CNT_W] = cls_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: directed test-plan cases plus random traffic.
module tb_retire_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trace_en;
    logic [5:0]       class_mask;
    logic             clr;
    logic             ret_valid;
    logic [XLEN-1:0]  ret_pc;
    logic [31:0]      ret_instr;
    logic             ret_rd_we;
    logic [XLEN-1:0]  ret_wb_data;
    logic             ret_br_taken;
    logic [XLEN-1:0]  ret_mem_addr;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_class;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_data;
    logic [LW-1:0]    level;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
    logic [6*CNT_W-1:0] class_count;
`endif

    retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .class_mask(class_mask),
        .clr(clr), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
        .ret_rd_we(ret_rd_we), .ret_wb_data(ret_wb_data),
        .ret_br_taken(ret_br_taken), .ret_mem_addr(ret_mem_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data),
        .level(level), .overflow(overflow), .drop_count(drop_count)
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
        , .class_count(class_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
    } ent_t;

    ent_t             exp_q[$];
    int               mlevel = 0;
    logic             movf = 1'b0;
    logic [CNT_W-1:0] mdrop = '0;
    logic [CNT_W-1:0] mcc[6] = '{default: '0};
    logic [31:0]      last_pc = '0;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [31:0] w);
        case (w[6:0])
            7'h33:   return 0;
            7'h13:   return 1;
            7'h03:   return 2;
            7'h23:   return 3;
            7'h63:   return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] pay_of(input int c, input logic we,
                                           input logic [31:0] wb, input logic br,
                                           input logic [31:0] addr);
        if (we) return wb;
        if (c == 3) return addr;
        if (c == 4) return {31'd0, br};
        return 32'd0;
    endfunction

    // Reference model: one step of the trace buffer per rising edge.
    always @(posedge clk or negedge rst) begin : model
        int   c;
        bit   pop, cap, push;
        ent_t e;
        if (!rst) begin
            exp_q.delete();
            mlevel = 0;
            movf   = 1'b0;
            mdrop  = '0;
            for (int k = 0; k < 6; k++) mcc[k] = '0;
        end else begin
            c    = cls_of(ret_instr);
            pop  = (mlevel > 0) && out_ready;
            cap  = ret_valid && trace_en && class_mask[c] && (ret_instr != 0);
            push = cap && (mlevel < DEPTH || pop);
            if (push) begin
                e.c     = 3'(c);
                e.pc    = ret_pc;
                e.instr = ret_instr;
                e.data  = pay_of(c, ret_rd_we, ret_wb_data, ret_br_taken, ret_mem_addr);
                exp_q.push_back(e);
            end
            mlevel = mlevel + int'(push) - int'(pop);
            if (clr) begin
                movf  = 1'b0;
                mdrop = '0;
            end else if (cap && !push) begin
                movf = 1'b1;
                if (mdrop != '1) mdrop = mdrop + 1;
            end
            for (int k = 0; k < 6; k++) begin
                if (clr) mcc[k] = '0;
                else if (ret_valid && ret_instr != 0 && c == k && mcc[k] != '1)
                    mcc[k] = mcc[k] + 1;
            end
        end
    end

    // Monitor: status every cycle, and each accepted head entry against the queue.
    always @(negedge clk) begin : monitor
        ent_t e;
        chk("level", 64'(level), 64'(mlevel));
        chk("out_valid", 64'(out_valid), 64'(mlevel != 0));
        chk("overflow", 64'(overflow), 64'(movf));
        chk("drop_count", 64'(drop_count), 64'(mdrop));
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
        for (int k = 0; k < 6; k++)
            chk("class_count", 64'(class_count[k*CNT_W +: CNT_W]), 64'(mcc[k]));
`endif
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_nonempty", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_class", 64'(out_class), 64'(e.c));
                chk("out_pc", 64'(out_pc), 64'(e.pc));
                chk("out_instr", 64'(out_instr), 64'(e.instr));
                chk("out_data", 64'(out_data), 64'(e.data));
                last_pc = e.pc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ret_valid    = 1'b0;
        ret_pc       = '0;
        ret_instr    = '0;
        ret_rd_we    = 1'b0;
        ret_wb_data  = '0;
        ret_br_taken = 1'b0;
        ret_mem_addr = '0;
        clr          = 1'b0;
    endtask

    task automatic ret(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                       input logic [31:0] wb, input logic br, input logic [31:0] addr);
        ret_valid    = 1'b1;
        ret_pc       = pc;
        ret_instr    = instr;
        ret_rd_we    = we;
        ret_wb_data  = wb;
        ret_br_taken = br;
        ret_mem_addr = addr;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4 && level != 0; i++) tick();
        chk("drain_empty", 64'(level), 64'(0));
        out_ready = 1'b0;
    endtask

    task automatic do_clr();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] op;
        if ($urandom_range(0, 15) == 0) return 32'd0;
        case ($urandom_range(0, 7))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            6: op = 7'b0110111;
            default: op = 7'($urandom());
        endcase
        return {25'($urandom()), op};
    endfunction

    localparam logic [31:0] ADD  = 32'h00208133;
    localparam logic [31:0] ADDI = 32'h00508093;
    localparam logic [31:0] SW   = 32'h00112223;
    localparam logic [31:0] BEQ  = 32'h00208463;

    initial begin
        idle();
        trace_en   = 1'b1;
        class_mask = 6'h3f;
        out_ready  = 1'b0;
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_drop", 64'(drop_count), 64'(0));
        rst = 1'b1;
        tick();

        ret(32'h10, ADD, 1'b1, 32'd7, 1'b0, 32'h55);
        tick();
        idle();
        chk("add_valid", 64'(out_valid), 64'(1));
        chk("add_class", 64'(out_class), 64'(0));
        chk("add_pc", 64'(out_pc), 64'(32'h10));
        chk("add_data", 64'(out_data), 64'(7));
        chk("add_level", 64'(level), 64'(1));
        drain();

        for (int i = 0; i < 18; i++) begin
            ret(32'h100 + 32'(4 * i), ADD, 1'b1, 32'(i), 1'b0, 32'd0);
            tick();
        end
        idle();
        chk("fill_level", 64'(level), 64'(16));
        chk("fill_overflow", 64'(overflow), 64'(1));
        chk("fill_drop", 64'(drop_count), 64'(2));
        drain();
        chk("fill_last", 64'(last_pc), 64'(32'h13c));

        for (int i = 0; i < DEPTH; i++) begin
            ret(32'h200 + 32'(4 * i), ADDI, 1'b1, 32'(i), 1'b0, 32'd0);
            tick();
        end
        ret(32'hbeef0, ADDI, 1'b1, 32'h99, 1'b0, 32'd0);
        out_ready = 1'b1;
        tick();
        idle();
        out_ready = 1'b0;
        chk("fullpop_level", 64'(level), 64'(16));
        chk("fullpop_drop", 64'(drop_count), 64'(2));
        drain();
        chk("fullpop_last", 64'(last_pc), 64'(32'hbeef0));

        do_clr();
        class_mask = 6'b010000;
        ret(32'h300, BEQ, 1'b0, 32'd0, 1'b1, 32'h44);
        tick();
        ret(32'h304, SW, 1'b0, 32'd0, 1'b0, 32'h80);
        tick();
        ret(32'h308, ADDI, 1'b1, 32'd3, 1'b0, 32'd0);
        tick();
        idle();
        chk("mask_level", 64'(level), 64'(1));
        chk("mask_class", 64'(out_class), 64'(4));
        chk("mask_data", 64'(out_data), 64'(1));
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
        chk("mask_cc1", 64'(class_count[1*CNT_W +: CNT_W]), 64'(1));
        chk("mask_cc3", 64'(class_count[3*CNT_W +: CNT_W]), 64'(1));
        chk("mask_cc4", 64'(class_count[4*CNT_W +: CNT_W]), 64'(1));
        chk("mask_cc0", 64'(class_count[0*CNT_W +: CNT_W]), 64'(0));
`endif
        drain();
        class_mask = 6'h3f;

        do_clr();
        ret(32'h400, 32'd0, 1'b1, 32'd1, 1'b0, 32'd0);
        tick();
        idle();
        chk("zero_level", 64'(level), 64'(0));
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
        chk("zero_cnt", 64'(class_count == '0), 64'(1));
`endif
        trace_en = 1'b0;
        ret(32'h404, ADD, 1'b1, 32'd1, 1'b0, 32'd0);
        tick();
        idle();
        trace_en = 1'b1;
        chk("off_level", 64'(level), 64'(0));
`ifdef RETIRE_TRACE_CLASS_COUNTERS_EN
        chk("off_cc0", 64'(class_count[0*CNT_W +: CNT_W]), 64'(1));
`endif

        for (int i = 0; i < 5; i++) begin
            ret(32'h500 + 32'(4 * i), ADD, 1'b1, 32'(i), 1'b0, 32'd0);
            tick();
        end
        idle();
        rst = 1'b0;
        #1;
        chk("arst_level", 64'(level), 64'(0));
        chk("arst_valid", 64'(out_valid), 64'(0));
        #1 rst = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            ret(32'h600 + 32'(4 * i), ADDI, 1'b1, 32'(i), 1'b0, 32'd0);
            tick();
        end
        chk("pre_clr_ovf", 64'(overflow), 64'(1));
        chk("pre_clr_drop", 64'(drop_count), 64'(1));
        clr = 1'b1;
        ret(32'h700, ADDI, 1'b1, 32'd9, 1'b0, 32'd0);
        tick();
        idle();
        chk("clr_drop", 64'(drop_count), 64'(0));
        chk("clr_ovf", 64'(overflow), 64'(0));
        chk("clr_level", 64'(level), 64'(16));
        drain();

        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0)
                class_mask = ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'h3f;
            ret_valid    = ($urandom_range(0, 3) != 0);
            ret_pc       = $urandom();
            ret_instr    = rnd_instr();
            ret_rd_we    = $urandom_range(0, 1) == 1;
            ret_wb_data  = $urandom();
            ret_br_taken = $urandom_range(0, 1) == 1;
            ret_mem_addr = $urandom();
            trace_en     = ($urandom_range(0, 7) != 0);
            clr          = ($urandom_range(0, 63) == 0);
            if ((i / 250) % 2 == 1) out_ready = ($urandom_range(0, 7) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        trace_en = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Synthesizable trace capture block that sits beside the RISC-V core's write-back stage and records every retired instruction into a parametrised FIFO. Each retirement is classified (R, I-ALU, load, store, branch, other), optionally filtered, and stored with its PC, instruction word and result payload. A valid/ready port drains the entries to a debug host or bench. Optional per-class retirement counters give on-chip instruction-mix statistics.

## Interface
- `XLEN`, 32: width of PC, data and address fields.
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `CNT_W`, 32: width of drop and class counters.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `trace_en`  in  1  capture enable; sampled every cycle.
- `class_mask`  in  6  bit k=1 allows class k to be captured; bit 5 = other.
- `clr`  in  1  synchronous clear of counters and the sticky overflow flag; FIFO untouched.
- `ret_valid`  in  1  an instruction retires this cycle.
- `ret_pc`  in  XLEN  PC of the retiring instruction.
- `ret_instr`  in  32  instruction word.
- `ret_rd_we`  in  1  register write enable.
- `ret_wb_data`  in  XLEN  write-back value.
- `ret_br_taken`  in  1  branch outcome.
- `ret_mem_addr`  in  XLEN  ALU result or store address.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_class`  out  3  head class code.
- `out_pc`  out  XLEN  head PC.
- `out_instr`  out  32  head instruction.
- `out_data`  out  XLEN  head payload.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `overflow`  out  1  sticky; set when an entry is dropped.
- `drop_count`  out  CNT_W  dropped entries, saturating.
- `class_count`  out  6*CNT_W  per-class retirement counts, class k at bits [k*CNT_W +: CNT_W] (present only with the macro).

## Operation
- Class from opcode `ret_instr[6:0]`: 0110011→0 R; 0010011→1 I-ALU; 0000011→2 LOAD; 0100011→3 STORE; 1100011→4 BRANCH; anything else→5 OTHER.
- Payload: `ret_wb_data` if `ret_rd_we`; else `ret_mem_addr` for STORE; else `{XLEN-1 zeros, ret_br_taken}` for BRANCH; else 0.
- Capture condition: `ret_valid & trace_en & class_mask[class] & (ret_instr != 0)`.
- Push on capture when not full, or when full and a pop happens in the same cycle.
- Capture while full with no pop: entry dropped, `overflow` set, `drop_count` increments, saturating at all-ones.
- Pop on `out_valid & out_ready`; head advances.
- Simultaneous push and pop: `level` unchanged; the new entry is written at tail.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full when `level == DEPTH`.
- `clr` takes priority over same-cycle increments: counters read 0 and `overflow` reads 0 afterwards, even if a drop or retirement occurs in that cycle.
- `out_*` fields present the head entry combinationally from storage; their value is don't-care when `out_valid` is 0.

## Timing
- Reset: `level`=0, `out_valid`=0, `overflow`=0, `drop_count`=0, all `class_count` fields=0, pointers=0; data fields undefined.
- Reset assertion mid-operation empties the FIFO immediately; no entry survives.
- Capture at edge N: entry visible on `out_*` with `out_valid`=1 after edge N (first-word fall-through, 1-cycle latency).
- `level`, `overflow` and counters update on the same edge as the event.
- `out_ready` may be held high permanently; the drain rate is then 1 entry per cycle.
- `out_valid` never drops without a pop.

## Configuration
- `RETIRE_TRACE_CLASS_COUNTERS_EN` defined: six CNT_W counters. Counter k increments on every `ret_valid & (ret_instr != 0)` of class k, independent of `trace_en`, `class_mask` and FIFO fullness. Counters saturate at all-ones and are cleared by `clr`.
- Not defined: `class_count` port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Retire ADD at PC 0x10 with wb 7, `out_ready`=0 → after one edge: `out_valid`=1, class 0, pc 0x10, data 7, `level`=1.
- DEPTH=16: 18 back-to-back captures with `out_ready`=0 → `level`=16, `overflow`=1, `drop_count`=2; the first 16 entries drain in order.
- FIFO full, capture and pop in the same cycle → `level` stays 16, no drop; the new entry is the last one drained.
- `class_mask`=6'b010000 with a BEQ (taken), a SW, and an ADDI retiring → only the BEQ is stored, payload 1; with the macro, `class_count` for classes 1, 3 and 4 each equals 1.
- Instruction word 0 with `ret_valid`=1, and a capture with `trace_en`=0 → nothing stored and no counter change for the zero word.
- Assert `rst` low with 5 entries held, then assert `clr` together with a drop → `level`=0 immediately after reset; after `clr`, `drop_count`=0 and `overflow`=0.
